multicycle_ctrl: RTL and testbench

Sequencing controller that turns the single-cycle RV32I datapath into a multicycle machine with variable-latency instruction and data memories. It sits beside the combinational control unit, which still decodes `Opcode`/`Function3`/`Function7` into datapath selects. This block decides when each architectural write happens: IR load, PC update, register-file write and data-memory write. It also handles memory handshakes, timeouts, illegal-opcode trapping and retired-instruction counting.

---
 rtl/multicycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencing controller for an RV32I datapath: decides when IR, PC,
// register file and data memory are written, and handles memory handshakes and traps.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Run,
  input  logic [6:0]       Opcode,
  output logic             IMReq,
  input  logic             IMAck,
  output logic             IRWr,
  output logic             DMReq,
  output logic             DMWrEn,
  input  logic             DMAck,
  output logic             RUWrEn,
  output logic             PCWr,
  output logic             Retire,
  output logic [CNT_W-1:0] InstRet,
  output logic             Halt,
  output logic             IllegalOp,
  output logic             BusErr,
  output logic [2:0]       State
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  // The wait counter only has to reach TIMEOUT-1 before the trap fires.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              is_load, is_store, is_branch, is_legal;
  logic              timeout_hit;
  logic              set_illegal, set_bus_err;

  always_comb begin
    is_load   = (Opcode == 7'b0000011);
    is_store  = (Opcode == 7'b0100011);
    is_branch = (Opcode == 7'b1100011);
    case (Opcode)
      7'b0110011, 7'b0010011, 7'b1100011, 7'b0100011, 7'b0000011,
      7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111: is_legal = 1'b1;
      default:                                         is_legal = 1'b0;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    IMReq       = 1'b0;
    IRWr        = 1'b0;
    DMReq       = 1'b0;
    DMWrEn      = 1'b0;
    RUWrEn      = 1'b0;
    PCWr        = 1'b0;
    Retire      = 1'b0;
    Halt        = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state_q)
      S_IDLE: if (Run) state_d = S_FETCH;
      S_FETCH: begin
        IMReq = 1'b1;
        // An ack in the timeout cycle still wins over the trap.
        if (IMAck) begin
          IRWr    = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          set_bus_err = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_DECODE: begin
        if (is_legal) state_d = S_EXEC;
        else begin
          set_illegal = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch) begin
          PCWr    = 1'b1;
          Retire  = 1'b1;
          state_d = Run ? S_FETCH : S_IDLE;
        end else state_d = S_WB;
      end
      S_MEM: begin
        DMReq  = 1'b1;
        DMWrEn = is_store;
        if (DMAck) begin
          if (is_store) begin
            PCWr    = 1'b1;
            Retire  = 1'b1;
            state_d = Run ? S_FETCH : S_IDLE;
          end else state_d = S_WB;
        end else if (timeout_hit) begin
          set_bus_err = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_WB: begin
        RUWrEn  = 1'b1;
        PCWr    = 1'b1;
        Retire  = 1'b1;
        state_d = Run ? S_FETCH : S_IDLE;
      end
      S_TRAP:  Halt = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // Any state change clears the wait counter, so it restarts on every FETCH/MEM entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_cnt  <= '0;
      InstRet   <= '0;
      IllegalOp <= 1'b0;
      BusErr    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= (state_d != state_q) ? '0 : wait_cnt + WAIT_W'(1);
      if (Retire)      InstRet   <= InstRet + CNT_W'(1);
      if (set_illegal) IllegalOp <= 1'b1;
      if (set_bus_err) BusErr    <= 1'b1;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scenario bench for multicycle_ctrl: per-cycle stimulus and expected outputs are queued
// together, then replayed against the DUT one cycle at a time.
module tb_multicycle_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DEC = 3'd2, ST_EXEC = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd7;
  localparam logic [9:0] IMQ = 10'h200, IRW = 10'h100, DMQ = 10'h080, DMW = 10'h040,
                         RUW = 10'h020, PCW = 10'h010, RET = 10'h008, HLT = 10'h004,
                         ILL = 10'h002, BER = 10'h001, NONE = 10'h000;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_BR = 7'b1100011,
                         OP_ST = 7'b0100011, OP_LD = 7'b0000011, OP_JALR = 7'b1100111,
                         OP_JAL = 7'b1101111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  logic       clk, rst_n, run, im_ack, dm_ack;
  logic [6:0] opcode;
  logic       im_req, ir_wr, dm_req, dm_wr_en, ru_wr_en, pc_wr, retire, halt, illegal_op, bus_err;
  logic [3:0] inst_ret;
  logic [2:0] state;

  logic [9:0]  stim_q[$];
  logic [16:0] exp_q[$];
  logic [3:0]  exp_ret;
  int          checks, errors;

  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Run(run), .Opcode(opcode),
    .IMReq(im_req), .IMAck(im_ack), .IRWr(ir_wr),
    .DMReq(dm_req), .DMWrEn(dm_wr_en), .DMAck(dm_ack),
    .RUWrEn(ru_wr_en), .PCWr(pc_wr), .Retire(retire), .InstRet(inst_ret),
    .Halt(halt), .IllegalOp(illegal_op), .BusErr(bus_err), .State(state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] obs();
    return {inst_ret, state, im_req, ir_wr, dm_req, dm_wr_en, ru_wr_en,
            pc_wr, retire, halt, illegal_op, bus_err};
  endfunction

  // driver: queue one cycle of stimulus with its expected outputs
  task automatic add(input logic r, input logic ia, input logic da, input logic [6:0] op,
                     input logic [2:0] st, input logic [9:0] m);
    stim_q.push_back({r, ia, da, op});
    exp_q.push_back({exp_ret, st, m});
    if (m[3]) exp_ret = exp_ret + 4'd1;
  endtask

  // driver: queue a whole instruction; mid = Run inside it, fin = Run on the retire cycle
  task automatic add_insn(input logic [6:0] op, input int im_wait, input int dm_wait,
                          input logic mid, input logic fin);
    logic [9:0] dm;
    for (int i = 0; i < im_wait; i++) add(mid, 1'b0, 1'b0, op, ST_FETCH, IMQ);
    add(mid, 1'b1, 1'b0, op, ST_FETCH, IMQ | IRW);
    add(mid, 1'b0, 1'b0, op, ST_DEC, NONE);
    if (op == OP_BR) add(fin, 1'b0, 1'b0, op, ST_EXEC, PCW | RET);
    else begin
      add(mid, 1'b0, 1'b0, op, ST_EXEC, NONE);
      if (op == OP_LD || op == OP_ST) begin
        dm = (op == OP_ST) ? (DMQ | DMW) : DMQ;
        for (int i = 0; i < dm_wait; i++) add(mid, 1'b0, 1'b0, op, ST_MEM, dm);
        if (op == OP_ST) add(fin, 1'b0, 1'b1, op, ST_MEM, dm | PCW | RET);
        else begin
          add(mid, 1'b0, 1'b1, op, ST_MEM, dm);
          add(fin, 1'b0, 1'b0, op, ST_WB, RUW | PCW | RET);
        end
      end else add(fin, 1'b0, 1'b0, op, ST_WB, RUW | PCW | RET);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; im_ack = 1'b0; dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 4'd0;
  endtask

  task automatic test_reset();
    logic [16:0] got;
    rst_n = 1'b0; run = 1'b0; im_ack = 1'b0; dm_ack = 1'b0; opcode = 7'd0;
    @(negedge clk); #1;
    got = obs(); checks++;
    if (got !== 17'd0) begin
      errors++; $display("FAIL reset_state: got %h expected %h", got, 17'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_ret = 4'd0;
    add(1'b0, 1'b0, 1'b0, OP_R, ST_IDLE, NONE);
    add(1'b0, 1'b0, 1'b0, OP_R, ST_IDLE, NONE);
    while (stim_q.size() != 0) begin
      logic [16:0] e;
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_idle: got %h expected %h", got, e); end
    end
  endtask

  task automatic test_rtype_back_to_back();
    logic [16:0] got, e;
    add(1'b1, 1'b0, 1'b0, OP_R, ST_IDLE, NONE);
    add_insn(OP_R, 0, 0, 1'b1, 1'b1);
    add_insn(OP_I, 0, 0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, OP_I, ST_IDLE, NONE);
    for (int c = 0; stim_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL rtype cyc%0d: got %h expected %h", c, got, e); end
    end
  endtask

  task automatic test_load_wait();
    logic [16:0] got, e;
    add(1'b1, 1'b0, 1'b0, OP_LD, ST_IDLE, NONE);
    add_insn(OP_LD, 0, 3, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, OP_LD, ST_IDLE, NONE);
    for (int c = 0; stim_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL load cyc%0d: got %h expected %h", c, got, e); end
    end
  endtask

  task automatic test_store();
    logic [16:0] got, e;
    add(1'b1, 1'b0, 1'b0, OP_ST, ST_IDLE, NONE);
    add_insn(OP_ST, 0, 1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, OP_ST, ST_IDLE, NONE);
    for (int c = 0; stim_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL store cyc%0d: got %h expected %h", c, got, e); end
    end
  endtask

  // Branch back-to-back into JAL, with Run dropped while the JAL is in flight.
  task automatic test_branch_run_drop();
    logic [16:0] got, e;
    add(1'b1, 1'b0, 1'b0, OP_BR, ST_IDLE, NONE);
    add_insn(OP_BR, 1, 0, 1'b1, 1'b1);
    add_insn(OP_JAL, 0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, OP_JAL, ST_IDLE, NONE);
    for (int c = 0; stim_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL branch cyc%0d: got %h expected %h", c, got, e); end
    end
  endtask

  task automatic test_illegal();
    logic [16:0] got, e;
    add(1'b1, 1'b0, 1'b0, 7'd0, ST_IDLE, NONE);
    add(1'b1, 1'b1, 1'b0, 7'd0, ST_FETCH, IMQ | IRW);
    add(1'b1, 1'b0, 1'b0, 7'd0, ST_DEC, NONE);
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b1, 7'd0, ST_TRAP, HLT | ILL);
    for (int c = 0; stim_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL illegal cyc%0d: got %h expected %h", c, got, e); end
    end
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    got = obs(); checks++;
    if (got !== 17'd0) begin errors++; $display("FAIL illegal_reset: got %h expected %h", got, 17'd0); end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0;
    exp_ret = 4'd0;
    add(1'b0, 1'b0, 1'b0, 7'd0, ST_IDLE, NONE);
    for (int c = 0; stim_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL illegal_clear: got %h expected %h", got, e); end
    end
  endtask

  task automatic test_timeout();
    logic [16:0] got, e;
    add(1'b1, 1'b0, 1'b0, OP_R, ST_IDLE, NONE);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 1'b0, OP_R, ST_FETCH, IMQ);
    add(1'b1, 1'b1, 1'b0, OP_R, ST_TRAP, HLT | BER);
    add(1'b1, 1'b0, 1'b0, OP_R, ST_TRAP, HLT | BER);
    for (int c = 0; stim_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL timeout cyc%0d: got %h expected %h", c, got, e); end
    end
    do_reset();
    add(1'b1, 1'b0, 1'b0, OP_R, ST_IDLE, NONE);
    add_insn(OP_R, 3, 0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, OP_R, ST_IDLE, NONE);
    for (int c = 0; stim_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL ack_wins cyc%0d: got %h expected %h", c, got, e); end
    end
  endtask

  task automatic test_reset_in_mem();
    logic [16:0] got, e;
    add(1'b1, 1'b0, 1'b0, OP_LD, ST_IDLE, NONE);
    add(1'b1, 1'b1, 1'b0, OP_LD, ST_FETCH, IMQ | IRW);
    add(1'b1, 1'b0, 1'b0, OP_LD, ST_DEC, NONE);
    add(1'b1, 1'b0, 1'b0, OP_LD, ST_EXEC, NONE);
    add(1'b1, 1'b0, 1'b0, OP_LD, ST_MEM, DMQ);
    add(1'b1, 1'b0, 1'b0, OP_LD, ST_MEM, DMQ);
    for (int c = 0; stim_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL mem_pre cyc%0d: got %h expected %h", c, got, e); end
    end
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    got = obs(); checks++;
    if (got !== 17'd0) begin errors++; $display("FAIL mem_reset: got %h expected %h", got, 17'd0); end
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0; dm_ack = 1'b1;
    exp_ret = 4'd0;
    add(1'b0, 1'b0, 1'b1, OP_LD, ST_IDLE, NONE);
    add(1'b0, 1'b0, 1'b0, OP_LD, ST_IDLE, NONE);
    for (int c = 0; stim_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL mem_after cyc%0d: got %h expected %h", c, got, e); end
    end
  endtask

  // 16 random instructions from reset: the 4-bit counter must come back to 0.
  task automatic test_wrap();
    logic [16:0] got, e;
    logic [6:0]  ops[9];
    ops = '{OP_R, OP_I, OP_BR, OP_ST, OP_LD, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC};
    do_reset();
    add(1'b1, 1'b0, 1'b0, OP_R, ST_IDLE, NONE);
    for (int n = 0; n < 16; n++)
      add_insn(ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), (n != 15));
    add(1'b0, 1'b0, 1'b0, OP_R, ST_IDLE, NONE);
    for (int c = 0; stim_q.size() != 0; c++) begin
      e = exp_q.pop_front();
      @(negedge clk); {run, im_ack, dm_ack, opcode} = stim_q.pop_front(); #1;
      got = obs(); checks++;
      if (got !== e) begin errors++; $display("FAIL wrap cyc%0d: got %h expected %h", c, got, e); end
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_ret = 4'd0;
    test_reset();
    test_rtype_back_to_back();
    test_load_wait();
    test_store();
    test_branch_run_drop();
    test_illegal();
    test_timeout();
    test_reset_in_mem();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
